// File: rtl/dmem_responder_pkg.sv
// Shared widths, MMIO address map and address decode for the MPS data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_ADDR_WIDTH = 8;
    localparam int unsigned DMEM_DATA_WIDTH = 8;
    localparam int unsigned DMEM_FIFO_DEPTH = 4;

    localparam logic [DMEM_ADDR_WIDTH-1:0] DMEM_STATUS_ADDR = 8'hFC;
    localparam logic [DMEM_ADDR_WIDTH-1:0] DMEM_CYCLE_ADDR  = 8'hFD;
    localparam logic [DMEM_ADDR_WIDTH-1:0] DMEM_IN_ADDR     = 8'hFE;
    localparam logic [DMEM_ADDR_WIDTH-1:0] DMEM_OUT_ADDR    = 8'hFF;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_IN,
        SEL_OUT
    } dmem_sel_e;

    function automatic dmem_sel_e dmem_decode(input logic [DMEM_ADDR_WIDTH-1:0] addr);
        case (addr)
            DMEM_STATUS_ADDR: return SEL_STATUS;
            DMEM_CYCLE_ADDR:  return SEL_CYCLE;
            DMEM_IN_ADDR:     return SEL_IN;
            DMEM_OUT_ADDR:    return SEL_OUT;
            default:          return SEL_RAM;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module mps_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM plus a four-register MMIO window (status, cycle counter, synced input, output FIFO).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DMEM_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_wenable,
    input  logic [DATA_WIDTH-1:0] dmem_wvalue,
    output logic [DATA_WIDTH-1:0] dmem_rvalue,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = DATA_WIDTH - 2;

    logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0] drop_q, drop_d;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    dmem_sel_e             sel;

    assign sel       = dmem_decode(dmem_addr);
    assign fifo_push = dmem_wenable && (sel == SEL_OUT);
    assign out_valid = !fifo_empty;

    mps_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .nreset    (nreset),
        .push      (fifo_push),
        .push_data (dmem_wvalue),
        .full      (fifo_full),
        .pop       (out_ready),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A full FIFO still accepts the push when the consumer pops on the same edge.
    always_comb begin
        cycle_d = (dmem_wenable && sel == SEL_CYCLE) ? dmem_wvalue : cycle_q + 1'b1;
        drop_d  = drop_q;
        if (fifo_push && fifo_full && !out_ready && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cycle_q <= '0;
            drop_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            drop_q  <= drop_d;
            sync1_q <= in_data;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (dmem_wenable && sel == SEL_RAM) begin
            ram_q[dmem_addr] <= dmem_wvalue;
        end
    end

    always_comb begin
        dmem_rvalue = '0;
        if (nreset) begin
            case (sel)
                SEL_STATUS: dmem_rvalue = {OCC_W'(fifo_count), fifo_full, fifo_empty};
                SEL_CYCLE:  dmem_rvalue = cycle_q;
                SEL_IN:     dmem_rvalue = sync2_q;
                SEL_OUT:    dmem_rvalue = drop_q;
                default:    dmem_rvalue = ram_q[dmem_addr];
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, CYCLE, FIFO, IN synchroniser and mid-run reset.
module tb_dmem_responder;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] dmem_addr = 8'h00;
    logic       dmem_wenable = 1'b0;
    logic [7:0] dmem_wvalue = 8'h00;
    logic [7:0] dmem_rvalue;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .dmem_addr    (dmem_addr),
        .dmem_wenable (dmem_wenable),
        .dmem_wvalue  (dmem_wvalue),
        .dmem_rvalue  (dmem_rvalue),
        .in_data      (in_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        dmem_wenable = 1'b0;
        dmem_addr    = a;
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] v);
        dmem_wenable = 1'b1;
        dmem_addr    = a;
        dmem_wvalue  = v;
        tick();
        dmem_wenable = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL reset_rvalue_forced got=%h exp=00", dmem_rvalue); end
        @(posedge clock);
        #1;
        nreset = 1'b1;
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL reset_status got=%h exp=01", dmem_rvalue); end
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL reset_cycle got=%h exp=00", dmem_rvalue); end
    endtask

    // Counter is 0 between release and the first edge, so nine edges later it reads 9.
    task automatic test_cycle();
        for (int i = 0; i < 9; i++) tick();
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'h09) begin failures++; $display("FAIL cycle_10th got=%h exp=09", dmem_rvalue); end
        wr(8'hFD, 8'hFE);
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'hFE) begin failures++; $display("FAIL cycle_load got=%h exp=fe", dmem_rvalue); end
        tick();
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'hFF) begin failures++; $display("FAIL cycle_plus1 got=%h exp=ff", dmem_rvalue); end
        tick();
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL cycle_wrap got=%h exp=00", dmem_rvalue); end
    endtask

    task automatic test_ram();
        wr(8'h10, 8'h5A);
        wr(8'hFB, 8'hA5);
        rd(8'h10);
        checks++; if (dmem_rvalue !== 8'h5A) begin failures++; $display("FAIL ram_10 got=%h exp=5a", dmem_rvalue); end
        rd(8'hFB);
        checks++; if (dmem_rvalue !== 8'hA5) begin failures++; $display("FAIL ram_fb got=%h exp=a5", dmem_rvalue); end
        wr(8'hFC, 8'h55);
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL status_write_ignored got=%h exp=01", dmem_rvalue); end
        wr(8'hFE, 8'h11);
        rd(8'hFE);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL in_write_ignored got=%h exp=00", dmem_rvalue); end
        rd(8'h10);
        checks++; if (dmem_rvalue !== 8'h5A) begin failures++; $display("FAIL ram_10_retained got=%h exp=5a", dmem_rvalue); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp;
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) wr(8'hFF, 8'(v));
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h12) begin failures++; $display("FAIL fifo_status_full got=%h exp=12", dmem_rvalue); end
        rd(8'hFF);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL fifo_drop_count got=%h exp=01", dmem_rvalue); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin failures++; $display("FAIL fifo_hold got=%b/%h exp=1/01", out_valid, out_data); end
        tick();
        checks++; if (out_data !== 8'h01) begin failures++; $display("FAIL fifo_stable got=%h exp=01", out_data); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL fifo_stream got=%b/%h exp=1/%h", out_valid, out_data, exp); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fifo_drained_valid got=%b exp=0", out_valid); end
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL fifo_drained_status got=%h exp=01", dmem_rvalue); end
        rd(8'hFF);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL fifo_drop_no_pop got=%h exp=01", dmem_rvalue); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
        out_ready = 1'b0;
        for (int v = 8'h10; v <= 8'h13; v++) wr(8'hFF, 8'(v));
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h12) begin failures++; $display("FAIL b2b_full got=%h exp=12", dmem_rvalue); end
        out_ready    = 1'b1;
        dmem_wenable = 1'b1;
        dmem_addr    = 8'hFF;
        dmem_wvalue  = 8'h77;
        #1;
        checks++; if (out_data !== 8'h10) begin failures++; $display("FAIL b2b_head got=%h exp=10", out_data); end
        tick();
        dmem_wenable = 1'b0;
        out_ready    = 1'b0;
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h12) begin failures++; $display("FAIL b2b_count got=%h exp=12", dmem_rvalue); end
        rd(8'hFF);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL b2b_no_drop got=%h exp=01", dmem_rvalue); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin failures++; $display("FAIL b2b_order got=%b/%h exp=1/%h", out_valid, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_in_sync();
        in_data = 8'h3C;
        rd(8'hFE);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL in_lat0 got=%h exp=00", dmem_rvalue); end
        tick();
        rd(8'hFE);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL in_lat1 got=%h exp=00", dmem_rvalue); end
        tick();
        rd(8'hFE);
        checks++; if (dmem_rvalue !== 8'h3C) begin failures++; $display("FAIL in_lat2 got=%h exp=3c", dmem_rvalue); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int v = 8'h21; v <= 8'h25; v++) wr(8'hFF, 8'(v));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h0C) begin failures++; $display("FAIL mr_pre_status got=%h exp=0c", dmem_rvalue); end
        rd(8'hFF);
        checks++; if (dmem_rvalue !== 8'h02) begin failures++; $display("FAIL mr_pre_drop got=%h exp=02", dmem_rvalue); end
        dmem_addr = 8'hFC;
        nreset    = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mr_out_data got=%h exp=00", out_data); end
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL mr_rvalue_forced got=%h exp=00", dmem_rvalue); end
        nreset = 1'b1;
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h01) begin failures++; $display("FAIL mr_status got=%h exp=01", dmem_rvalue); end
        rd(8'hFF);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL mr_drop got=%h exp=00", dmem_rvalue); end
        rd(8'hFD);
        checks++; if (dmem_rvalue !== 8'h00) begin failures++; $display("FAIL mr_cycle got=%h exp=00", dmem_rvalue); end
        wr(8'hFF, 8'h99);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin failures++; $display("FAIL mr_first_push got=%b/%h exp=1/99", out_valid, out_data); end
        rd(8'hFC);
        checks++; if (dmem_rvalue !== 8'h04) begin failures++; $display("FAIL mr_post_status got=%h exp=04", dmem_rvalue); end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ram();
        test_fifo_full();
        test_back_to_back();
        test_in_sync();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
